// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM state encoding, default widths, command record.
package alu_seq_pkg;

  localparam int DATA_W = 15;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
  } cmd_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// One ALU op per command: read A, read B, execute, write back; ALU_SEQ_FWD_EN adds last-result forwarding.
// Latency: accept edge + 5 cycles, write in cycle 5, next accept possible in cycle 6.
// Backpressure: cmd_ready only in IDLE; the source holds its command while busy.
module alu_seq_ctrl #(
  parameter int DATA_W = alu_seq_pkg::DATA_W,
  parameter int ADDR_W = alu_seq_pkg::ADDR_W,
  parameter int OP_W   = alu_seq_pkg::OP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              busy
);
  import alu_seq_pkg::*;

  state_t            state_q, state_d;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, res_q;
  logic              accept;
  logic              fwd_a, fwd_b;
  logic [DATA_W-1:0] cap_a, cap_b;

  assign accept = cmd_valid && cmd_ready;

`ifdef ALU_SEQ_FWD_EN
  logic [ADDR_W-1:0] last_dst_q;
  logic [DATA_W-1:0] last_res_q;
  logic              last_vld_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_dst_q <= '0;
      last_res_q <= '0;
      last_vld_q <= 1'b0;
    end else if (state_q == WB) begin
      last_dst_q <= cmd_q.dst;
      last_res_q <= res_q;
      last_vld_q <= 1'b1;
    end
  end

  // A hit skips the memory read; the operand comes from the last written result instead.
  assign fwd_a = last_vld_q && (cmd_q.src_a == last_dst_q);
  assign fwd_b = last_vld_q && (cmd_q.src_b == last_dst_q);
  assign cap_a = fwd_a ? last_res_q : mem_data_out;
  assign cap_b = fwd_b ? last_res_q : mem_data_out;
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
  assign cap_a = mem_data_out;
  assign cap_b = mem_data_out;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q <= '{op: cmd_op, src_a: cmd_src_a, src_b: cmd_src_b, dst: cmd_dst};
      end
      // Read data lags the address by one cycle, so A lands in RD_B and B in CAP_B.
      if (state_q == RD_B)  op_a_q <= cap_a;
      if (state_q == CAP_B) op_b_q <= cap_b;
      if (state_q == EXEC)  res_q  <= alu_result;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    mem_ren   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = RD_A;
      end
      RD_A: begin
        mem_ren = !fwd_a;
        state_d = RD_B;
      end
      RD_B: begin
        mem_ren = !fwd_b;
        state_d = CAP_B;
      end
      CAP_B:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset landing on WB must not commit a partial command.
  assign mem_wen     = done && !reset;
  assign mem_rd_addr = (state_q == RD_B) ? cmd_q.src_b : cmd_q.src_a;
  assign mem_wr_addr = cmd_q.dst;
  assign mem_data_in = res_q;
  assign alu_op      = cmd_q.op;
  assign alu_a       = op_a_q;
  assign alu_b       = op_b_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with an 8x15 registered-read memory and add/sub ALU beside it.
module tb_alu_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op, cmd_src_a, cmd_src_b, cmd_dst;
  logic        mem_ren, mem_wen;
  logic [2:0]  mem_rd_addr, mem_wr_addr;
  logic [14:0] mem_data_out, mem_data_in;
  logic [2:0]  alu_op;
  logic [14:0] alu_a, alu_b, alu_result;
  logic        done, busy;

  logic [14:0] mem [8];
  logic        preload;
  int          wen_count = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  alu_seq_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_src_a    (cmd_src_a),
    .cmd_src_b    (cmd_src_b),
    .cmd_dst      (cmd_dst),
    .mem_ren      (mem_ren),
    .mem_rd_addr  (mem_rd_addr),
    .mem_data_out (mem_data_out),
    .mem_wen      (mem_wen),
    .mem_wr_addr  (mem_wr_addr),
    .mem_data_in  (mem_data_in),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .done         (done),
    .busy         (busy)
  );

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 15'(i);
    end else begin
      if (mem_ren) mem_data_out <= mem[mem_rd_addr];
      if (mem_wen) mem[mem_wr_addr] <= mem_data_in;
    end
  end

  always @(posedge clock) if (mem_wen === 1'b1) wen_count++;

  assign alu_result = (alu_op == 3'd0) ? alu_a + alu_b : alu_a - alu_b;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_preload;
    preload = 1'b1;
    tick;
    preload = 1'b0;
  endtask

  task automatic set_cmd(input logic [2:0] op, a, b, d);
    cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
  endtask

  // Issues one command from IDLE and logs cycles 1..6 after the accept edge (bit k = cycle k+1).
  task automatic run_cmd(input logic [2:0] op, a, b, d,
                         output logic [5:0] ren_v, wen_v, done_v, rdy_v,
                         output logic [2:0] addr1, addr2);
    int w = 0;
    while (!cmd_ready && w < 10) begin tick; w++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL run_cmd_ready_timeout actual=%b required=1", cmd_ready);
    end
    set_cmd(op, a, b, d);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    addr1 = '0; addr2 = '0;
    for (int k = 0; k < 6; k++) begin
      ren_v[k] = mem_ren; wen_v[k] = mem_wen; done_v[k] = done; rdy_v[k] = cmd_ready;
      if (k == 0) addr1 = mem_rd_addr;
      if (k == 1) addr2 = mem_rd_addr;
      if (k < 5) tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; preload = 1'b1;
    tick; tick;
    reset = 1'b0; preload = 1'b0;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready actual=%b required=1", cmd_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy actual=%b required=0", busy); end
    tests++; if ({done, mem_ren, mem_wen} !== 3'b000) begin fails++; $display("FAIL reset_strobes actual=%b required=000", {done, mem_ren, mem_wen}); end
    tests++; if ({mem_rd_addr, mem_wr_addr, mem_data_in, alu_a, alu_b, alu_op} !== 54'd0) begin
      fails++; $display("FAIL reset_buses actual=%h required=0", {mem_rd_addr, mem_wr_addr, mem_data_in, alu_a, alu_b, alu_op});
    end
  endtask

  task automatic test_single;
    logic [5:0] ren_v, wen_v, done_v, rdy_v;
    logic [2:0] a1, a2;
    do_preload;
    run_cmd(3'd0, 3'd2, 3'd5, 3'd7, ren_v, wen_v, done_v, rdy_v, a1, a2);
    tests++; if (ren_v !== 6'b000011) begin fails++; $display("FAIL single_ren actual=%b required=000011", ren_v); end
    tests++; if (a1 !== 3'd2) begin fails++; $display("FAIL single_addr_a actual=%0d required=2", a1); end
    tests++; if (a2 !== 3'd5) begin fails++; $display("FAIL single_addr_b actual=%0d required=5", a2); end
    tests++; if (wen_v !== 6'b010000) begin fails++; $display("FAIL single_wen actual=%b required=010000", wen_v); end
    tests++; if (done_v !== 6'b010000) begin fails++; $display("FAIL single_done actual=%b required=010000", done_v); end
    tests++; if (rdy_v !== 6'b100000) begin fails++; $display("FAIL single_ready actual=%b required=100000", rdy_v); end
    tests++; if (mem[7] !== 15'd7) begin fails++; $display("FAIL single_mem7 actual=%0d required=7", mem[7]); end
  endtask

  task automatic test_back_to_back;
    int n = 0, a0 = 0, a1 = 0;
    do_preload;
    set_cmd(3'd0, 3'd1, 3'd3, 3'd4);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid && cmd_ready) begin
        if (n == 0) a0 = i; else a1 = i;
        n++;
      end
      tick;
      if (n == 1) set_cmd(3'd0, 3'd4, 3'd4, 3'd6);
      if (n >= 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    tests++; if (n !== 2) begin fails++; $display("FAIL b2b_accepts actual=%0d required=2", n); end
    tests++; if (a1 - a0 !== 6) begin fails++; $display("FAIL b2b_spacing actual=%0d required=6", a1 - a0); end
    tests++; if (mem[4] !== 15'd4) begin fails++; $display("FAIL b2b_mem4 actual=%0d required=4", mem[4]); end
    tests++; if (mem[6] !== 15'd8) begin fails++; $display("FAIL b2b_mem6 actual=%0d required=8", mem[6]); end
  endtask

  task automatic test_reset_exec;
    int base;
    do_preload;
    base = wen_count;
    set_cmd(3'd0, 3'd3, 3'd3, 3'd0);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick; tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_exec_ready actual=%b required=1", cmd_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_exec_busy actual=%b required=0", busy); end
    repeat (6) tick;
    tests++; if (wen_count !== base) begin fails++; $display("FAIL rst_exec_writes actual=%0d required=%0d", wen_count, base); end
    tests++; if (mem[0] !== 15'd0) begin fails++; $display("FAIL rst_exec_mem0 actual=%0d required=0", mem[0]); end
  endtask

  task automatic test_reset_wb;
    int base;
    do_preload;
    base = wen_count;
    set_cmd(3'd0, 3'd2, 3'd2, 3'd1);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (4) tick;
    tests++; if (mem_wen !== 1'b1) begin fails++; $display("FAIL rst_wb_in_wb actual=%b required=1", mem_wen); end
    reset = 1'b1;
    #1;
    tests++; if (mem_wen !== 1'b0) begin fails++; $display("FAIL rst_wb_gate actual=%b required=0", mem_wen); end
    tick;
    reset = 1'b0;
    #1;
    tests++; if (mem[1] !== 15'd1) begin fails++; $display("FAIL rst_wb_mem1 actual=%0d required=1", mem[1]); end
    tests++; if (wen_count !== base) begin fails++; $display("FAIL rst_wb_writes actual=%0d required=%0d", wen_count, base); end
  endtask

  task automatic test_busy_pulse;
    int base;
    do_preload;
    base = wen_count;
    set_cmd(3'd0, 3'd2, 3'd3, 3'd6);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    set_cmd(3'd0, 3'd1, 3'd1, 3'd5);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (6) tick;
    tests++; if (wen_count - base !== 1) begin fails++; $display("FAIL busy_writes actual=%0d required=1", wen_count - base); end
    tests++; if (mem[6] !== 15'd5) begin fails++; $display("FAIL busy_mem6 actual=%0d required=5", mem[6]); end
    tests++; if (mem[5] !== 15'd5) begin fails++; $display("FAIL busy_mem5 actual=%0d required=5", mem[5]); end
  endtask

  task automatic test_fwd;
    logic [5:0] ren_v, wen_v, done_v, rdy_v, exp_ren;
    logic [2:0] a1, a2;
`ifdef ALU_SEQ_FWD_EN
    exp_ren = 6'b000010;
`else
    exp_ren = 6'b000011;
`endif
    do_preload;
    run_cmd(3'd0, 3'd1, 3'd2, 3'd5, ren_v, wen_v, done_v, rdy_v, a1, a2);
    tests++; if (mem[5] !== 15'd3) begin fails++; $display("FAIL fwd_mem5 actual=%0d required=3", mem[5]); end
    run_cmd(3'd0, 3'd5, 3'd1, 3'd3, ren_v, wen_v, done_v, rdy_v, a1, a2);
    tests++; if (ren_v !== exp_ren) begin fails++; $display("FAIL fwd_ren actual=%b required=%b", ren_v, exp_ren); end
    tests++; if (mem[3] !== 15'd4) begin fails++; $display("FAIL fwd_mem3 actual=%0d required=4", mem[3]); end
  endtask

  initial begin
    reset = 1'b1; preload = 1'b0; cmd_valid = 1'b0;
    set_cmd(3'd0, 3'd0, 3'd0, 3'd0);
    test_reset;
    test_single;
    test_back_to_back;
    test_reset_exec;
    test_reset_wb;
    test_busy_pulse;
    test_fwd;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command sequencer that drives one ALU operation per command against the shared 8 x 15-bit operand memory. It reads two source operands through the memory's single read port, presents them to the combinational ALU, and writes the result back through the write port. It sits between the host command source and the memory/ALU pair, and is the only master of the memory's ren/wen.

## Interface
- DATA_W, 15, operand/result width (matches memory word)
- ADDR_W, 3, memory address width (8 entries)
- OP_W, 3, ALU opcode width, passed through untouched
- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept (IDLE only)
- cmd_op  in  OP_W  ALU opcode
- cmd_src_a, cmd_src_b  in  ADDR_W  operand addresses
- cmd_dst  in  ADDR_W  result address
- mem_ren  out  1  memory read enable
- mem_rd_addr  out  ADDR_W  memory read address
- mem_data_out  in  DATA_W  memory read data (registered, 1-cycle latency)
- mem_wen  out  1  memory write enable
- mem_wr_addr  out  ADDR_W  memory write address
- mem_data_in  out  DATA_W  memory write data
- alu_op  out  OP_W  latched opcode
- alu_a, alu_b  out  DATA_W  latched operands
- alu_result  in  DATA_W  combinational ALU result
- done  out  1  one-cycle pulse during write-back
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RD_A, RD_B, CAP_B, EXEC, WB.
- IDLE: cmd_ready=1. cmd_valid&&cmd_ready at an edge latches op/src_a/src_b/dst, then -> RD_A.
- RD_A: mem_ren=1, mem_rd_addr=src_a -> RD_B.
- RD_B: mem_ren=1, mem_rd_addr=src_b; op_a_q <= mem_data_out -> CAP_B.
- CAP_B: op_b_q <= mem_data_out -> EXEC.
- EXEC: alu_a/alu_b/alu_op come from registers; res_q <= alu_result -> WB.
- WB: mem_wen=1, mem_wr_addr=dst, mem_data_in=res_q, done=1 -> IDLE.
- Outside these states, mem_ren, mem_wen and done are 0. Addresses and data hold their last latched values.
- Result is taken as-is at DATA_W bits. The controller applies no carry or overflow handling.
- cmd_ready is 0 in every non-IDLE state. Commands offered while busy are not accepted and must be held by the source.
- dst equal to src_a/src_b, or src_a == src_b: legal. Reads happen before the write, so old values are used.

## Timing
- Reset (any state): the next state is IDLE. op_a_q, op_b_q, res_q, latched fields and the last-write tracking are cleared to 0.
- Reset outputs in the cycle after reset: cmd_ready=1; busy, done, mem_ren, mem_wen = 0; all buses 0.
- mem_wen is gated with !reset, so reset asserted during WB suppresses that write.
- Reset mid-command aborts it with no memory update.
- Accept at edge E0. States then run RD_A (cycle 1), RD_B (2), CAP_B (3), EXEC (4), WB (5). The write commits at the end of cycle 5, and cmd_ready=1 again in cycle 6.
- Throughput: one command per 6 cycles with back-to-back valid.
- A dependent next command (src == previous dst) reads at cycle 7 or later and sees the new value.

## Configuration
- ALU_SEQ_FWD_EN defined:
  - last_dst_q / last_res_q / last_vld_q are updated in WB. last_vld_q is cleared by reset.
  - If src_a (src_b) equals last_dst_q with last_vld_q=1, mem_ren is held 0 in RD_A (RD_B).
  - The operand is then loaded from last_res_q in the cycle where it would have been captured from memory.
  - State sequence and latency are unchanged.
- Undefined: both operands are always read from memory. No last-write registers exist.

## Structure
- Shared package alu_seq_pkg:
  - state enum typedef (IDLE..WB);
  - DATA_W/ADDR_W/OP_W default localparams;
  - command struct typedef {op, src_a, src_b, dst}.
- No sub-module: FSM and datapath registers in one module. Memory and ALU are instantiated beside it at the level above.

## Test plan
- Memory preloaded mem[i]=i, bench ALU op 0 = add:
  - cmd op=0 a=2 b=5 dst=7 -> mem_ren in cycles 1-2, mem_wen in cycle 5, mem[7]=7, done one cycle, cmd_ready back in cycle 6.
- Back-to-back, cmd_valid held:
  - (0,1,3,dst=4) then (0,4,4,dst=6) -> mem[4]=4, mem[6]=8, second accept exactly 6 cycles after the first.
- Reset asserted during EXEC of a=3 b=3 dst=0 -> no mem_wen, mem[0]=0. The next cycle shows cmd_ready=1 and busy=0.
- Reset asserted coincident with WB -> mem_wen=0 that cycle, destination unchanged.
- cmd_valid pulsed while busy -> ignored, only one write observed.
- ALU_SEQ_FWD_EN: cmd (0,1,2,dst=5) then (0,5,1,dst=3):
  - mem_ren low in RD_A of the second command, high in RD_B;
  - mem[3]=4.
  - Without the macro, same result with mem_ren high in both read cycles.
